// File: rtl/layer1_writer_if.sv
// layer1_writer_if: groups the writer's accumulator input stream and the
// layer1 SRAM port A signals.
//   in_valid/in_data/in_ready : 32-bit accumulator stream with handshake
//   flush                     : end-of-stream pulse
//   WEAN/OEA/A/DIA            : SRAM wrapper port A (write-only use)
// The master modport is the writer's view; slave is the environment's view.
interface layer1_writer_if #(
  parameter int AW = 10,
  parameter int DW = 128
);
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          flush;
  logic          WEAN;
  logic          OEA;
  logic [AW-1:0] A;
  logic [DW-1:0] DIA;

  modport master (
    input  in_valid, in_data, flush,
    output in_ready, WEAN, OEA, A, DIA
  );

  modport slave (
    output in_valid, in_data, flush,
    input  in_ready, WEAN, OEA, A, DIA
  );
endinterface

// File: rtl/layer1_writer.sv
// layer1_writer: requantizes 32-bit layer-1 accumulator results to 16 bits
// (arithmetic shift, optional ReLU, saturation), packs LANES results into one
// word and writes the words to sequential layer1 SRAM addresses from 0.
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   start    : pulse, begins a new layer fill (only honoured in IDLE)
//   bus      : input stream + SRAM port A (see layer1_writer_if)
//   busy     : high while filling
//   done     : one-cycle pulse after the last write
//   word_cnt : words written since start
module layer1_writer #(
  parameter int DEPTH      = 912,
  parameter int LANES      = 8,
  parameter int FRAC_SHIFT = 8,
  parameter int RELU_EN    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  layer1_writer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [9:0]      word_cnt
);
  localparam int AW = 10;
  localparam int DW = 16 * LANES;
  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [LW-1:0] lane_r, lane_s;
  logic [DW-1:0] pack_r, pack_s, merged_s;
  logic [DW-1:0] dia_r;
  logic [AW-1:0] word_cnt_r, wr_addr_s, a_r;
  logic          wean_r, in_ready_r, busy_r, done_r;
  logic          accept_s, wr_s, start_s;
  logic [15:0]   q_s;

  // Shift, optional ReLU, then saturate to the signed 16-bit range.
  function automatic logic [15:0] requant(input logic [31:0] d);
    logic signed [31:0] q;
    q = $signed(d) >>> FRAC_SHIFT;
    if ((RELU_EN != 0) && (q < 32'sd0)) begin
      q = 32'sd0;
    end
    if (q > 32'sd32767) begin
      return 16'h7FFF;
    end else if (q < -32'sd32768) begin
      return 16'h8000;
    end else begin
      return q[15:0];
    end
  endfunction

  // Next-state, packing and write-request decode.
  always_comb begin
    state_s  = state_r;
    lane_s   = lane_r;
    pack_s   = pack_r;
    wr_s     = 1'b0;
    accept_s = bus.in_valid && in_ready_r;
    start_s  = start && (state_r == IDLE);
    q_s      = requant(bus.in_data);
    // A commit landing in the previous word's write cycle targets the next address.
    wr_addr_s = wean_r ? word_cnt_r : (word_cnt_r + AW'(1));
    merged_s  = pack_r;
    if (accept_s) begin
      merged_s[{lane_r, 4'b0000} +: 16] = q_s;
    end else begin
      merged_s = pack_r;
    end
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = FILL;
          lane_s  = '0;
          pack_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        // Data in the flush cycle is merged first, so pack and pad share one write.
        if (accept_s && ((lane_r == LAST_LANE) || bus.flush)) begin
          wr_s = 1'b1;
        end else if (!accept_s && bus.flush && (lane_r != '0)) begin
          wr_s = 1'b1;
        end else begin
          wr_s = 1'b0;
        end
        if (wr_s) begin
          lane_s = '0;
          pack_s = '0;
        end else if (accept_s) begin
          lane_s = lane_r + LW'(1);
          pack_s = merged_s;
        end else begin
          lane_s = lane_r;
          pack_s = pack_r;
        end
        if (bus.flush) begin
          state_s = wr_s ? DRAIN : DONE;
        end else if (wr_s && (wr_addr_s == LAST_WORD)) begin
          state_s = DRAIN;
        end else begin
          state_s = FILL;
        end
      end
      DRAIN:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, pack register and registered port-A / status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      lane_r     <= '0;
      pack_r     <= '0;
      wean_r     <= 1'b1;
      a_r        <= '0;
      dia_r      <= '0;
      word_cnt_r <= '0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      lane_r     <= lane_s;
      pack_r     <= pack_s;
      wean_r     <= ~wr_s;
      in_ready_r <= (state_s == FILL);
      busy_r     <= (state_s == FILL);
      done_r     <= (state_s == DONE);
      if (wr_s) begin
        a_r   <= wr_addr_s;
        dia_r <= merged_s;
      end else if (start_s) begin
        a_r <= '0;
      end else begin
        a_r <= a_r;
      end
      // The count advances at the end of each WEAN=0 cycle.
      if (start_s) begin
        word_cnt_r <= '0;
      end else if (!wean_r) begin
        word_cnt_r <= word_cnt_r + AW'(1);
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.WEAN     = wean_r;
  assign bus.OEA      = 1'b0;
  assign bus.A        = a_r;
  assign bus.DIA      = dia_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign word_cnt     = word_cnt_r;
endmodule
